// File: rtl/fwd_pkg.sv
// Shared types and helpers for the forwarding / load-use hazard unit.
package fwd_pkg;

  // Widest register address any instance may use; narrower addresses are zero-extended.
  localparam int unsigned FWD_AW_MAX = 8;

  localparam int unsigned SEL_BYPASS_NONE = 0;

  typedef struct packed {
    logic                  v;
    logic [FWD_AW_MAX-1:0] rd;
    logic                  wr;
    logic                  ld;
  } fwd_rec_t;

  function automatic int unsigned sel_w(input int unsigned depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fwd_src_match.sv
// Priority match of one source register against the in-flight destination records.
// Emits the bypass select the instruction will need in EX and a load-too-young flag.
module fwd_src_match
  import fwd_pkg::*;
#(
  parameter int unsigned AW       = 5,
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned LOAD_LAT = 2,
  parameter bit          ZERO_REG = 1'b1,
  parameter int unsigned SELW     = sel_w(DEPTH)
) (
  input  logic [AW-1:0]          rs,
  input  fwd_rec_t [DEPTH-1:0]   recs,
  output logic [SELW-1:0]        sel,
  output logic                   load_young
);

  logic [DEPTH-1:0] match;
  logic             rs_is_zero;

  assign rs_is_zero = ZERO_REG && (rs == '0);

  always_comb begin
    match = '0;
    for (int j = 0; j < int'(DEPTH); j++) begin
      match[j] = recs[j].v && recs[j].wr && (recs[j].rd == FWD_AW_MAX'(rs)) && !rs_is_zero;
    end
  end

  // Walk oldest to youngest so the youngest match is the one left standing.
  always_comb begin
    sel        = SELW'(SEL_BYPASS_NONE);
    load_young = 1'b0;
    for (int j = int'(DEPTH) - 1; j >= 0; j--) begin
      if (match[j]) begin
        sel        = SELW'(j + 1);
        load_young = recs[j].ld && ((j + 1) < int'(LOAD_LAT));
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Shadow pipeline of in-flight destinations: registered bypass selects for the
// instruction entering EX, load-use stall detection and a saturating stall counter.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int unsigned AW       = 5,
  parameter int unsigned NUM_SRC  = 2,
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned LOAD_LAT = 2,
  parameter bit          ZERO_REG = 1'b1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              id_valid,
  input  logic [NUM_SRC*AW-1:0]             id_rs,
  input  logic [AW-1:0]                     id_rd,
  input  logic                              id_reg_write,
  input  logic                              id_mem_read,
  input  logic                              ex_ready,
  input  logic                              flush,
  output logic                              hazard_stall,
  output logic                              ex_valid,
  output logic [NUM_SRC*sel_w(DEPTH)-1:0]   ex_fwd_sel,
  output logic [CNT_W-1:0]                  stall_cnt
);

  localparam int unsigned SELW = sel_w(DEPTH);

  // The last post-EX stage retires into the regfile (write-before-read), so it is never matched
  // and needs no tracking: only EX and the first DEPTH-1 post-EX stages are kept.
  fwd_rec_t [DEPTH-1:0]      rec_q, rec_d;
  logic [NUM_SRC*SELW-1:0]   sel_q, sel_d, next_sel;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [NUM_SRC-1:0]        load_young;

  for (genvar i = 0; i < int'(NUM_SRC); i++) begin : g_src
    fwd_src_match #(
      .AW       (AW),
      .DEPTH    (DEPTH),
      .LOAD_LAT (LOAD_LAT),
      .ZERO_REG (ZERO_REG),
      .SELW     (SELW)
    ) u_match (
      .rs         (id_rs[i*AW +: AW]),
      .recs       (rec_q),
      .sel        (next_sel[i*SELW +: SELW]),
      .load_young (load_young[i])
    );
  end

  assign hazard_stall = id_valid && !flush && (|load_young);
  assign ex_valid     = rec_q[0].v;
  assign ex_fwd_sel   = sel_q;
  assign stall_cnt    = cnt_q;

  always_comb begin
    rec_d = rec_q;
    sel_d = sel_q;
    cnt_d = cnt_q;
    if (ex_ready) begin
      for (int j = 1; j < int'(DEPTH); j++) begin
        rec_d[j] = rec_q[j-1];
      end
      rec_d[0] = '0;
      sel_d    = '0;
      // hazard_stall already folds in flush, so a single test covers both bubble cases.
      if (id_valid && !flush && !hazard_stall) begin
        rec_d[0].v  = 1'b1;
        rec_d[0].rd = FWD_AW_MAX'(id_rd);
        rec_d[0].wr = id_reg_write;
        rec_d[0].ld = id_mem_read;
        sel_d       = next_sel;
      end
      if (hazard_stall && (cnt_q != '1)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rec_q <= '0;
      sel_q <= '0;
      cnt_q <= '0;
    end else begin
      rec_q <= rec_d;
      sel_q <= sel_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench: vector table plus hand sequences for stall, freeze, flush, reset, saturation.
module tb_fwd_hazard_unit;

  typedef struct {
    logic       v;
    logic [4:0] rs1, rs2, rd;
    logic       wr, ld, rdy, fl;
    logic       stall;
    logic       ev;
    logic [3:0] sel;
  } vec_t;

  typedef struct {
    logic       ev;
    logic [3:0] sel;
  } exp_t;

  logic        clk, rst_n;
  logic        id_valid, id_reg_write, id_mem_read, ex_ready, flush;
  logic [9:0]  id_rs;
  logic [4:0]  id_rd;

  logic        stall_a, ev_a, stall_b, ev_b, stall_s, ev_s;
  logic [3:0]  sel_a, sel_b, sel_s;
  logic [15:0] cnt_a, cnt_b;
  logic [1:0]  cnt_s;

  int n_tests = 0;
  int n_fail  = 0;
  exp_t sb[$];

  fwd_hazard_unit u_dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .ex_ready(ex_ready), .flush(flush),
    .hazard_stall(stall_a), .ex_valid(ev_a), .ex_fwd_sel(sel_a), .stall_cnt(cnt_a)
  );

  fwd_hazard_unit #(.DEPTH(3), .LOAD_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .ex_ready(ex_ready), .flush(flush),
    .hazard_stall(stall_b), .ex_valid(ev_b), .ex_fwd_sel(sel_b), .stall_cnt(cnt_b)
  );

  fwd_hazard_unit #(.CNT_W(2)) u_dut_sat (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .ex_ready(ex_ready), .flush(flush),
    .hazard_stall(stall_s), .ex_valid(ev_s), .ex_fwd_sel(sel_s), .stall_cnt(cnt_s)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [4:0] rd, input logic wr, input logic ld,
                              input logic rdy, input logic fl, input logic stall,
                              input logic ev, input logic [3:0] sel);
    vec_t t;
    t.v = v; t.rs1 = rs1; t.rs2 = rs2; t.rd = rd; t.wr = wr; t.ld = ld;
    t.rdy = rdy; t.fl = fl; t.stall = stall; t.ev = ev; t.sel = sel;
    return t;
  endfunction

  // which: 0 = default instance, 1 = DEPTH=3/LOAD_LAT=3 instance
  task automatic apply(input vec_t t, input string name, input int which);
    exp_t e;
    logic st, ev;
    logic [3:0] sl;
    id_valid = t.v; id_rs = {t.rs2, t.rs1}; id_rd = t.rd;
    id_reg_write = t.wr; id_mem_read = t.ld; ex_ready = t.rdy; flush = t.fl;
    sb.push_back('{ev: t.ev, sel: t.sel});
    @(negedge clk);
    st = (which == 1) ? stall_b : stall_a;
    chk({name, ".stall"}, 32'(st), 32'(t.stall));
    @(posedge clk);
    #1;
    e  = sb.pop_front();
    ev = (which == 1) ? ev_b : ev_a;
    sl = (which == 1) ? sel_b : sel_a;
    chk({name, ".ex_valid"}, 32'(ev), 32'(e.ev));
    chk({name, ".sel"}, 32'(sl), 32'(e.sel));
  endtask

  vec_t tbl[16];
  vec_t bub, lw3, use3;

  initial begin
    //          v  rs1 rs2 rd wr ld rdy fl  stall ev sel
    tbl[0]  = mk(0,  0,  0,  0, 0, 0, 1, 0, 0, 0, 4'b0000);
    tbl[1]  = mk(1,  1,  2,  5, 1, 0, 1, 0, 0, 1, 4'b0000); // add x5
    tbl[2]  = mk(1,  5,  6,  8, 1, 0, 1, 0, 0, 1, 4'b0001); // x5 in EX -> 1
    tbl[3]  = mk(1,  6,  5,  9, 1, 0, 1, 0, 0, 1, 4'b1000); // x5 one gap -> 2
    tbl[4]  = mk(1,  5,  9,  0, 0, 0, 1, 0, 0, 1, 4'b0100); // x5 gap of 2 -> 0
    tbl[5]  = mk(0,  0,  0,  0, 0, 0, 1, 0, 0, 0, 4'b0000);
    tbl[6]  = mk(1,  8,  9, 10, 1, 0, 1, 0, 0, 1, 4'b0000);
    tbl[7]  = mk(1,  1,  2,  7, 1, 0, 1, 0, 0, 1, 4'b0000); // x7 first writer
    tbl[8]  = mk(1,  7,  0,  7, 1, 0, 1, 0, 0, 1, 4'b0001); // x7 second writer
    tbl[9]  = mk(1,  7,  7, 11, 1, 0, 1, 0, 0, 1, 4'b0101); // youngest wins
    tbl[10] = mk(1,  3,  4,  0, 1, 0, 1, 0, 0, 1, 4'b0000); // writes x0
    tbl[11] = mk(1,  0,  0, 12, 1, 0, 1, 0, 0, 1, 4'b0000); // reads x0
    tbl[12] = mk(1,  1,  2,  0, 1, 1, 1, 0, 0, 1, 4'b0000); // load to x0
    tbl[13] = mk(1,  0, 12, 13, 1, 0, 1, 0, 0, 1, 4'b1000); // no stall on x0
    tbl[14] = mk(0,  0,  0,  0, 0, 0, 1, 0, 0, 0, 4'b0000);
    tbl[15] = mk(0,  0,  0,  0, 0, 0, 1, 0, 0, 0, 4'b0000);

    bub  = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 4'b0000);
    lw3  = mk(1, 1, 2, 3, 1, 1, 1, 0, 0, 1, 4'b0000);

    rst_n = 1'b1;
    id_valid = 0; id_rs = '0; id_rd = '0; id_reg_write = 0; id_mem_read = 0;
    ex_ready = 1; flush = 0;
    #1 rst_n = 1'b0;
    #2;
    chk("reset.ex_valid", 32'(ev_a), 0);
    chk("reset.sel", 32'(sel_a), 0);
    chk("reset.cnt", 32'(cnt_a), 0);
    chk("reset.stall", 32'(stall_a), 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 16; i++) apply(tbl[i], $sformatf("vec%0d", i), 0);

    // Load-use, LOAD_LAT=2: one stall, then bypass from MEM/WB.
    apply(lw3, "lu.lw", 0);
    apply(mk(1, 4, 3, 14, 1, 0, 1, 0, 1, 0, 4'b0000), "lu.stall", 0);
    apply(mk(1, 4, 3, 14, 1, 0, 1, 0, 0, 1, 4'b1000), "lu.go", 0);
    chk("lu.cnt", 32'(cnt_a), 1);

    // Freeze during a stall: outputs and counter hold.
    apply(lw3, "frz.lw", 0);
    for (int i = 0; i < 3; i++)
      apply(mk(1, 3, 5, 15, 1, 0, 0, 0, 1, 1, 4'b0000), $sformatf("frz.hold%0d", i), 0);
    chk("frz.cnt_hold", 32'(cnt_a), 1);
    apply(mk(1, 3, 5, 15, 1, 0, 1, 0, 1, 0, 4'b0000), "frz.stall", 0);
    apply(mk(1, 3, 5, 15, 1, 0, 1, 0, 0, 1, 4'b0010), "frz.go", 0);
    chk("frz.cnt", 32'(cnt_a), 2);

    // Flush in the would-be stall cycle.
    apply(lw3, "fl.lw", 0);
    apply(mk(1, 4, 3, 14, 1, 0, 1, 1, 0, 0, 4'b0000), "fl.flush", 0);
    chk("fl.cnt", 32'(cnt_a), 2);

    // Asynchronous reset in the middle of a stall.
    apply(lw3, "rst.lw", 0);
    id_valid = 1; id_rs = {5'd3, 5'd4}; id_rd = 5'd14; id_reg_write = 1; id_mem_read = 0;
    ex_ready = 1; flush = 0;
    @(negedge clk);
    chk("rst.pre_stall", 32'(stall_a), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst.ex_valid", 32'(ev_a), 0);
    chk("rst.sel", 32'(sel_a), 0);
    chk("rst.cnt", 32'(cnt_a), 0);
    chk("rst.stall", 32'(stall_a), 0);
    id_valid = 0;
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // LOAD_LAT=3, DEPTH=3: two stalls, then sel=3.
    use3 = mk(1, 4, 3, 14, 1, 0, 1, 0, 1, 0, 4'b0000);
    apply(lw3, "ll3.lw", 1);
    apply(use3, "ll3.stall0", 1);
    apply(use3, "ll3.stall1", 1);
    apply(mk(1, 4, 3, 14, 1, 0, 1, 0, 0, 1, 4'b1100), "ll3.go", 1);
    chk("ll3.cnt", 32'(cnt_b), 2);

    // Repeated load-use pairs drive the 2-bit counter into saturation.
    for (int r = 0; r < 5; r++) begin
      apply(lw3, $sformatf("sat%0d.lw", r), 0);
      apply(mk(1, 4, 3, 14, 1, 0, 1, 0, 1, 0, 4'b0000), $sformatf("sat%0d.stall", r), 0);
      apply(mk(1, 4, 3, 14, 1, 0, 1, 0, 0, 1, 4'b1000), $sformatf("sat%0d.go", r), 0);
      if (r == 2) chk("sat.cnt_reach", 32'(cnt_s), 3);
    end
    chk("sat.cnt_hold", 32'(cnt_s), 3);
    chk("sat.cnt_wide", 32'(cnt_a), 6);

    apply(bub, "end.bub", 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
